// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Time-multiplexed scan controller for a 3-digit 7-segment display.
//            Drives a shared segment bus and one-hot digit select with a dark
//            gap between digits, optional leading-zero blanking and
//            frame-aligned (tear-free) code updates.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seg_scan_ctrl #(
    parameter int DIGIT_CYC = 50000,
    parameter int GAP_CYC   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [23:0] i_code,
    input  logic        i_load,
    input  logic        i_lz_en,
    input  logic        i_en,
    output logic [7:0]  o_seg,
    output logic [2:0]  o_sel,
    output logic        o_frame
);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_GAP  = 2'd1,
        S_SHOW = 2'd2
    } state_t;

    localparam logic [15:0] c_DIGIT_LAST = 16'(DIGIT_CYC - 1);
    // With no gap the GAP state is never entered, so this value is unused.
    localparam logic [15:0] c_GAP_LAST   = (GAP_CYC > 0) ? 16'(GAP_CYC - 1) : 16'd0;
    localparam bit          c_HAS_GAP    = (GAP_CYC > 0);
    localparam logic [7:0]  c_SEG_ZERO   = 8'hfc;

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [15:0] r_cnt;
    logic [23:0] r_pend_code;
    logic        r_pend_lz;
    logic [23:0] r_act_code;
    logic        r_act_lz;

    state_t      w_state_nxt;
    state_t      w_after_slot;
    logic [1:0]  w_idx_nxt;
    logic [15:0] w_cnt_nxt;
    logic        w_frame_start;
    logic [7:0]  w_digit;
    logic        w_blank_h;
    logic        w_blank_t;
    logic        w_blank;

    // Next-state logic: en low overrides everything; frame starts flag the
    // moment the pending code may be promoted to the active code.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_frame_start = 1'b0;
        w_after_slot  = c_HAS_GAP ? S_GAP : S_SHOW;
        if (!i_en) begin
            w_state_nxt = S_OFF;
            w_idx_nxt   = 2'd0;
            w_cnt_nxt   = 16'd0;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_state_nxt   = w_after_slot;
                    w_idx_nxt     = 2'd0;
                    w_cnt_nxt     = 16'd0;
                    w_frame_start = 1'b1;
                end
                S_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        w_cnt_nxt   = 16'd0;
                        w_state_nxt = S_SHOW;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
                S_SHOW: begin
                    if (r_cnt == c_DIGIT_LAST) begin
                        w_cnt_nxt   = 16'd0;
                        w_state_nxt = w_after_slot;
                        if (r_idx == 2'd2) begin
                            w_idx_nxt     = 2'd0;
                            w_frame_start = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + 2'd1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_OFF;
                    w_idx_nxt   = 2'd0;
                    w_cnt_nxt   = 16'd0;
                end
            endcase
        end
    end

    // Digit byte selection and leading-zero blanking for the current slot.
    always_comb begin
        w_blank_h = r_act_lz && (r_act_code[23:16] == c_SEG_ZERO);
        w_blank_t = w_blank_h && (r_act_code[15:8] == c_SEG_ZERO);
        case (r_idx)
            2'd1:    begin w_digit = r_act_code[15:8];  w_blank = w_blank_t; end
            2'd2:    begin w_digit = r_act_code[23:16]; w_blank = w_blank_h; end
            default: begin w_digit = r_act_code[7:0];   w_blank = 1'b0;      end
        endcase
    end

    // Scan state, slot counter and digit index registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_OFF;
            r_idx   <= 2'd0;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Double buffer: loads land in pending; active takes the old pending
    // value only at a frame start, so a same-cycle load waits one frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend_code <= 24'd0;
            r_pend_lz   <= 1'b0;
            r_act_code  <= 24'd0;
            r_act_lz    <= 1'b0;
        end else begin
            if (i_load) begin
                r_pend_code <= i_code;
                r_pend_lz   <= i_lz_en;
            end
            if (w_frame_start) begin
                r_act_code <= r_pend_code;
                r_act_lz   <= r_pend_lz;
            end
        end
    end

    // Registered outputs follow the current state one cycle later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_seg   <= 8'h00;
            o_sel   <= 3'b000;
            o_frame <= 1'b0;
        end else begin
            o_sel   <= (r_state == S_SHOW) ? (3'b001 << r_idx) : 3'b000;
            o_seg   <= ((r_state == S_SHOW) && !w_blank) ? w_digit : 8'h00;
            o_frame <= (r_state == S_SHOW) && (r_idx == 2'd0) && (r_cnt == 16'd0);
        end
    end

endmodule

`default_nettype wire
